// File: rtl/sonar_echo_emulator_if.sv
// Sensor-side bundle between the sonar interface and the echo emulator.
// The master drives the trigger and the distance; the slave answers with the echo.
interface sonar_echo_emulator_if #(
   parameter int DIST_W = 9
);
   logic              trigger;
   logic [DIST_W-1:0] distancia;
   logic              presente;
   logic              echo;
   logic              ocupado;
   logic              erro_trigger;
   logic [2:0]        db_estado;

   modport master (
      output trigger, distancia, presente,
      input  echo, ocupado, erro_trigger, db_estado
   );

   modport slave (
      input  trigger, distancia, presente,
      output echo, ocupado, erro_trigger, db_estado
   );
endinterface

// File: rtl/sonar_echo_emulator.sv
// HC-SR04 emulator: a valid trigger pulse yields an echo whose width encodes distancia.
// Define EMU_JITTER_EN to add 0..15 cycles of LFSR jitter to every echo width.
module sonar_echo_emulator #(
   parameter int TRIG_MIN_CYC = 500,
   parameter int BURST_CYC    = 22500,
   parameter int CYC_PER_CM   = 2941,
   parameter int DIST_W       = 9,
   parameter int MIN_DIST     = 2,
   parameter int MAX_DIST     = 400,
   parameter int TIMEOUT_CYC  = 1900000,
   parameter int HOLDOFF_CYC  = 500000
) (
   input  logic                 clock,
   input  logic                 reset,
   sonar_echo_emulator_if.slave bus
);
   localparam int CW = 32;
   localparam logic [CW-1:0] ONE = 1;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      TRIG  = 3'd1,
      BURST = 3'd2,
      ECHO  = 3'd3,
      HOLD  = 3'd4
   } state_e;

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [CW-1:0] width_q;
   logic          echo_q, echo_d;
   logic          busy_q, busy_d;
   logic          err_q, err_d;
   logic          sync1_q, sync2_q, prev_q;
   logic          trig_s, lat;
   logic [CW-1:0] dist_ext, base_w, jit_w;

   assign trig_s   = sync2_q;
   assign dist_ext = CW'(bus.distancia);

   always_comb begin
      if (!bus.presente || dist_ext > CW'(MAX_DIST))
         base_w = CW'(TIMEOUT_CYC);
      else if (dist_ext < CW'(MIN_DIST))
         base_w = CW'(MIN_DIST) * CW'(CYC_PER_CM);
      else
         base_w = dist_ext * CW'(CYC_PER_CM);
   end

`ifdef EMU_JITTER_EN
   logic [7:0] lfsr_q, lfsr_d;
   logic       fb;

   // x^8+x^6+x^5+x^4+1, stepped once per accepted measurement
   assign fb     = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
   assign lfsr_d = lat ? {lfsr_q[6:0], fb} : lfsr_q;
   assign jit_w  = base_w + CW'(lfsr_q[3:0]);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) lfsr_q <= 8'hA5;
      else        lfsr_q <= lfsr_d;
   end
`else
   assign jit_w = base_w;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      echo_d  = echo_q;
      err_d   = 1'b0;
      lat     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (trig_s && !prev_q) begin
               state_d = TRIG;
               cnt_d   = ONE;
            end
         end
         TRIG: begin
            if (trig_s) begin
               if (cnt_q < CW'(TRIG_MIN_CYC)) cnt_d = cnt_q + ONE;
            end else if (cnt_q >= CW'(TRIG_MIN_CYC)) begin
               state_d = BURST;
               cnt_d   = ONE;
               lat     = 1'b1;
            end else begin
               state_d = IDLE;
               cnt_d   = '0;
               err_d   = 1'b1;
            end
         end
         // the TRIG cycle that saw the fall counts as the first burst cycle
         BURST: begin
            if (cnt_q >= CW'(BURST_CYC - 1)) begin
               state_d = ECHO;
               cnt_d   = ONE;
               echo_d  = 1'b1;
            end else cnt_d = cnt_q + ONE;
         end
         ECHO: begin
            if (cnt_q >= width_q) begin
               state_d = HOLD;
               cnt_d   = ONE;
               echo_d  = 1'b0;
            end else cnt_d = cnt_q + ONE;
         end
         HOLD: begin
            if (cnt_q >= CW'(HOLDOFF_CYC)) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else cnt_d = cnt_q + ONE;
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
            echo_d  = 1'b0;
         end
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         width_q <= '0;
         echo_q  <= 1'b0;
         busy_q  <= 1'b0;
         err_q   <= 1'b0;
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         prev_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         echo_q  <= echo_d;
         busy_q  <= busy_d;
         err_q   <= err_d;
         sync1_q <= bus.trigger;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
         if (lat) width_q <= jit_w;
      end
   end

   assign bus.echo         = echo_q;
   assign bus.ocupado      = busy_q;
   assign bus.erro_trigger = err_q;
   assign bus.db_estado    = state_q;
endmodule

// File: tb/tb_sonar_echo_emulator.sv
// Bench for sonar_echo_emulator with scaled-down timing parameters.
// Random and directed measurements are compared with a distance-to-width reference model.
module tb_sonar_echo_emulator;
   localparam int TMIN = 20;
   localparam int BRST = 50;
   localparam int CPC  = 3;
   localparam int MIND = 2;
   localparam int MAXD = 400;
   localparam int TO   = 1500;
   localparam int HOLD = 100;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   failures = 0;
   int   lfsr_m = 'hA5;

   sonar_echo_emulator_if #(.DIST_W(9)) u_if ();

   sonar_echo_emulator #(
      .TRIG_MIN_CYC(TMIN),
      .BURST_CYC   (BRST),
      .CYC_PER_CM  (CPC),
      .DIST_W      (9),
      .MIN_DIST    (MIND),
      .MAX_DIST    (MAXD),
      .TIMEOUT_CYC (TO),
      .HOLDOFF_CYC (HOLD)
   ) dut (
      .clock(clk),
      .reset(rst_n),
      .bus  (u_if.slave)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int ref_width(int d, bit p, int k);
      int w;
      if (!p || d > MAXD) w = TO;
      else if (d < MIND)  w = MIND * CPC;
      else                w = d * CPC;
      return w + k;
   endfunction

   function automatic int jitter_take();
`ifdef EMU_JITTER_EN
      int k;
      int fb;
      k = lfsr_m % 16;
      fb = ((lfsr_m >> 7) ^ (lfsr_m >> 5) ^ (lfsr_m >> 4) ^ (lfsr_m >> 3)) & 1;
      lfsr_m = ((lfsr_m << 1) | fb) & 255;
      return k;
`else
      return 0;
`endif
   endfunction

   task automatic measure(input int tlen, input int d, input bit p,
                          input bit poke_echo, input bit hold_trig);
      int rise;
      int w;
      int errs;
      int exp_w;
      bit seen;
      rise = 0; w = 0; errs = 0; seen = 1'b0;
      u_if.distancia = 9'(d);
      u_if.presente  = p;
      u_if.trigger   = 1'b1;
      repeat (tlen) @(negedge clk);
      u_if.trigger = 1'b0;
      if (tlen < TMIN) begin
         for (int i = 0; i < BRST + 20; i++) begin
            @(negedge clk);
            if (u_if.erro_trigger) errs++;
            if (u_if.echo) seen = 1'b1;
         end
         check("short_err", errs, 1);
         check("short_echo", 32'(seen), 0);
         check("short_busy", 32'(u_if.ocupado), 0);
         return;
      end
      exp_w = ref_width(d, p, jitter_take());
      for (int i = 1; i <= BRST + 20; i++) begin
         @(negedge clk);
         if (i == 5) begin
            u_if.distancia = 9'($urandom);
            u_if.presente  = ~p;
         end
         if (u_if.echo) begin
            rise = i;
            break;
         end
      end
      check("echo_rise", rise, BRST + 2);
      check("echo_state", 32'(u_if.db_estado), 3);
      if (rise != 0) begin
         w = 1;
         for (int i = 0; i < TO + 100; i++) begin
            u_if.trigger = poke_echo && w >= 10 && w < 10 + TMIN + 5;
            @(negedge clk);
            if (!u_if.echo) break;
            w++;
         end
      end
      u_if.trigger = 1'b0;
      check("echo_width", w, exp_w);
      check("hold_state", 32'(u_if.db_estado), 4);
      for (int i = 0; i < HOLD + BRST + 30; i++) begin
         u_if.trigger = hold_trig &&
                        ((i >= 10 && i < 10 + TMIN + 5) || i >= HOLD - 10);
         @(negedge clk);
         if (u_if.echo) seen = 1'b1;
      end
      check("hold_echo", 32'(seen), 0);
      check("idle_state", 32'(u_if.db_estado), 0);
      check("idle_busy", 32'(u_if.ocupado), 0);
      u_if.trigger = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   initial begin
      int tl;
      int d;
      bit p;
      bit got;
      u_if.trigger   = 1'b0;
      u_if.distancia = '0;
      u_if.presente  = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_echo", 32'(u_if.echo), 0);
      check("rst_busy", 32'(u_if.ocupado), 0);
      check("rst_err", 32'(u_if.erro_trigger), 0);
      check("rst_state", 32'(u_if.db_estado), 0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      measure(TMIN + 10, 100, 1'b1, 1'b0, 1'b0);
      measure(TMIN - 5, 100, 1'b1, 1'b0, 1'b0);
      measure(TMIN - 1, 100, 1'b1, 1'b0, 1'b0);
      measure(TMIN, 57, 1'b1, 1'b0, 1'b0);
      measure(TMIN + 3, 50, 1'b0, 1'b0, 1'b0);
      measure(TMIN + 3, 450, 1'b1, 1'b0, 1'b0);
      measure(TMIN + 3, 0, 1'b1, 1'b0, 1'b0);
      measure(TMIN + 3, 1, 1'b1, 1'b0, 1'b0);
      measure(TMIN + 3, 2, 1'b1, 1'b0, 1'b0);
      measure(TMIN + 3, 400, 1'b1, 1'b0, 1'b0);
      measure(TMIN + 3, 401, 1'b1, 1'b0, 1'b0);
      measure(TMIN + 5, 100, 1'b1, 1'b1, 1'b1);
      measure(TMIN + 5, 77, 1'b1, 1'b0, 1'b0);

      // abort mid-echo
      u_if.distancia = 9'd100;
      u_if.presente  = 1'b1;
      u_if.trigger   = 1'b1;
      repeat (TMIN + 5) @(negedge clk);
      u_if.trigger = 1'b0;
      void'(jitter_take());
      got = 1'b0;
      for (int i = 0; i < BRST + 20; i++) begin
         @(negedge clk);
         if (u_if.echo) begin
            got = 1'b1;
            break;
         end
      end
      check("abort_rise", 32'(got), 1);
      repeat (20) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("abort_echo", 32'(u_if.echo), 0);
      check("abort_state", 32'(u_if.db_estado), 0);
      check("abort_busy", 32'(u_if.ocupado), 0);
      lfsr_m = 'hA5;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      measure(TMIN + 5, 120, 1'b1, 1'b0, 1'b0);

      for (int n = 0; n < 8; n++) begin
         tl = $urandom_range(TMIN + 30, TMIN - 8);
         d  = $urandom_range(511, 0);
         p  = ($urandom_range(7, 0) != 0);
         measure(tl, d, p, 1'b0, 1'b0);
      end

      for (int n = 0; n < 3; n++) measure(TMIN + 2, 10, 1'b1, 1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end
endmodule
